// File: rtl/cia_pkg.sv
// cia_pkg: shared constants for the CIA timer block.
//   - register indices of the CPU-visible map
//   - control-register bit positions and writable-bit masks
//   - timer B input-mode encodings
package cia_pkg;

    // Register indices (CPU ab[3:0])
    localparam logic [3:0] REG_TA_LO = 4'h4;
    localparam logic [3:0] REG_TA_HI = 4'h5;
    localparam logic [3:0] REG_TB_LO = 4'h6;
    localparam logic [3:0] REG_TB_HI = 4'h7;
    localparam logic [3:0] REG_ICR   = 4'hD;
    localparam logic [3:0] REG_CRA   = 4'hE;
    localparam logic [3:0] REG_CRB   = 4'hF;

    // Control-register bit positions
    localparam int CR_START      = 0;
    localparam int CR_ONESHOT    = 3;
    localparam int CR_FORCE_LOAD = 4;
    localparam int CR_INMODE_LO  = 5;
    localparam int CR_INMODE_HI  = 6;

    // Bits that are actually stored; FORCE_LOAD is a strobe and never stored.
    // CRA keeps bit 5 as plain storage, CRB uses bits 6:5 as INMODE.
    localparam logic [7:0] CRA_MASK = 8'h29;
    localparam logic [7:0] CRB_MASK = 8'h69;

    // Timer B count-source selection
    typedef enum logic [1:0] {
        INMODE_TICK = 2'b00,
        INMODE_RSV1 = 2'b01,
        INMODE_TA   = 2'b10,
        INMODE_RSV3 = 2'b11
    } inmode_e;

endpackage

// File: rtl/cia_timer_unit.sv
// cia_timer_unit: one 16-bit down-counting timer with reload latch.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   tick              phi2 count strobe
//   casc_uf           underflow of the preceding timer (used when HAS_INMODE=1)
//   wr_lo/wr_hi/wr_cr write strobes for the low latch byte, high latch byte, control reg
//   di                write data
//   counter           live counter value
//   cr                stored control register (FORCE_LOAD always reads 0)
//   underflow         combinational underflow in the current cycle
module cia_timer_unit
    import cia_pkg::*;
#(
    parameter logic [7:0] CR_MASK    = CRA_MASK,
    parameter bit         HAS_INMODE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        casc_uf,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_cr,
    input  logic [7:0]  di,
    output logic [15:0] counter,
    output logic [7:0]  cr,
    output logic        underflow
);

    logic [15:0] latch_r;
    logic [15:0] counter_r;
    logic [7:0]  cr_r;

    logic        src_s;
    logic        force_s;
    logic        event_s;
    logic        underflow_s;
    inmode_e     inmode_s;

    // Count-event qualification and underflow detection
    always_comb begin
        src_s    = 1'b0;
        inmode_s = inmode_e'(cr_r[CR_INMODE_HI:CR_INMODE_LO]);
        if (HAS_INMODE) begin
            case (inmode_s)
                INMODE_TICK: src_s = tick;
                INMODE_TA:   src_s = casc_uf;
                default:     src_s = 1'b0;
            endcase
        end else begin
            src_s = tick;
        end
        force_s = wr_cr & di[CR_FORCE_LOAD];
        // START uses the pre-edge value, so a write that sets START counts from the next cycle.
        // A force load pre-empts any count in the same cycle.
        event_s     = cr_r[CR_START] & src_s & ~force_s;
        underflow_s = event_s & (counter_r == 16'h0000);
    end

    // Latch, counter and control-register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_r   <= 16'hFFFF;
            counter_r <= 16'h0000;
            cr_r      <= 8'h00;
        end else begin
            if (wr_lo) begin
                latch_r[7:0] <= di;
            end
            if (wr_hi) begin
                latch_r[15:8] <= di;
            end

            // Reload paths read latch_r, i.e. the value before any write in this edge.
            if (force_s) begin
                counter_r <= latch_r;
            end else if (wr_hi && !cr_r[CR_START]) begin
                counter_r <= {di, latch_r[7:0]};
            end else if (underflow_s) begin
                counter_r <= latch_r;
            end else if (event_s) begin
                counter_r <= counter_r - 16'd1;
            end

            if (wr_cr) begin
                cr_r <= di & CR_MASK;
            end else if (underflow_s && cr_r[CR_ONESHOT]) begin
                cr_r[CR_START] <= 1'b0;
            end
        end
    end

    assign counter   = counter_r;
    assign cr        = cr_r;
    assign underflow = underflow_s;

endmodule

// File: rtl/cia_timers.sv
// cia_timers: CIA-style pair of 16-bit interval timers with interrupt control.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   tick        phi2 count strobe
//   cs, addr    chip select and register index (CPU ab[3:0])
//   we, di      write enable and write data
//   dout        registered read data (CPU data-in via bus mux)
//   irq_n       registered active-low interrupt request
module cia_timers
    import cia_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cs,
    input  logic [3:0] addr,
    input  logic       we,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       irq_n
);

    logic        wr_s;
    logic        rd_s;
    logic        icr_rd_s;
    logic        icr_wr_s;
    logic        ir_s;
    logic [1:0]  flags_nxt_s;
    logic [1:0]  mask_nxt_s;
    logic [7:0]  rd_data_s;

    logic [15:0] ta_cnt_s;
    logic [15:0] tb_cnt_s;
    logic [7:0]  cra_s;
    logic [7:0]  crb_s;
    logic        ta_uf_s;
    logic        tb_uf_s;

    logic [1:0]  flags_r;
    logic [1:0]  mask_r;
    logic [7:0]  dout_r;
    logic        irq_n_r;

    assign wr_s = cs & we;
    assign rd_s = cs & ~we;

    cia_timer_unit #(
        .CR_MASK    (CRA_MASK),
        .HAS_INMODE (1'b0)
    ) u_timer_a (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .casc_uf   (1'b0),
        .wr_lo     (wr_s && (addr == REG_TA_LO)),
        .wr_hi     (wr_s && (addr == REG_TA_HI)),
        .wr_cr     (wr_s && (addr == REG_CRA)),
        .di        (di),
        .counter   (ta_cnt_s),
        .cr        (cra_s),
        .underflow (ta_uf_s)
    );

    cia_timer_unit #(
        .CR_MASK    (CRB_MASK),
        .HAS_INMODE (1'b1)
    ) u_timer_b (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .casc_uf   (ta_uf_s),
        .wr_lo     (wr_s && (addr == REG_TB_LO)),
        .wr_hi     (wr_s && (addr == REG_TB_HI)),
        .wr_cr     (wr_s && (addr == REG_CRB)),
        .di        (di),
        .counter   (tb_cnt_s),
        .cr        (crb_s),
        .underflow (tb_uf_s)
    );

    // Interrupt flag/mask next state
    always_comb begin
        icr_rd_s = rd_s & (addr == REG_ICR);
        icr_wr_s = wr_s & (addr == REG_ICR);
        ir_s     = |(flags_r & mask_r);
        // A same-cycle underflow wins over the read-clear.
        flags_nxt_s = (icr_rd_s ? 2'b00 : flags_r) | {tb_uf_s, ta_uf_s};
        if (icr_wr_s) begin
            if (di[7]) begin
                mask_nxt_s = mask_r | di[1:0];
            end else begin
                mask_nxt_s = mask_r & ~di[1:0];
            end
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Read multiplexer
    always_comb begin
        rd_data_s = 8'h00;
        case (addr)
            REG_TA_LO: rd_data_s = ta_cnt_s[7:0];
            REG_TA_HI: rd_data_s = ta_cnt_s[15:8];
            REG_TB_LO: rd_data_s = tb_cnt_s[7:0];
            REG_TB_HI: rd_data_s = tb_cnt_s[15:8];
            REG_ICR:   rd_data_s = {ir_s, 5'b00000, flags_r};
            REG_CRA:   rd_data_s = cra_s;
            REG_CRB:   rd_data_s = crb_s;
            default:   rd_data_s = 8'h00;
        endcase
    end

    // Interrupt state, read data and irq_n registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 2'b00;
            mask_r  <= 2'b00;
            dout_r  <= 8'h00;
            irq_n_r <= 1'b1;
        end else begin
            flags_r <= flags_nxt_s;
            mask_r  <= mask_nxt_s;
            irq_n_r <= ~ir_s;
            if (rd_s) begin
                dout_r <= rd_data_s;
            end
        end
    end

    assign dout  = dout_r;
    assign irq_n = irq_n_r;

endmodule

// File: tb/tb_cia_timers.sv
// tb_cia_timers: directed self-checking bench for cia_timers.
module tb_cia_timers;
    import cia_pkg::*;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       cs;
    logic [3:0] addr;
    logic       we;
    logic [7:0] di;
    logic [7:0] dout;
    logic       irq_n;

    int n_tests;
    int n_fail;

    cia_timers dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .cs    (cs),
        .addr  (addr),
        .we    (we),
        .di    (di),
        .dout  (dout),
        .irq_n (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus write cycle; tk is the tick level during that cycle.
    task automatic write_reg(input logic [3:0] a, input logic [7:0] d, input logic tk);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; di = d; tick = tk;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; tick = 1'b0;
    endtask

    // One bus read cycle; data is sampled on the following falling edge.
    task automatic read_reg(input logic [3:0] a, input logic tk, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a; tick = tk;
        @(negedge clk);
        cs = 1'b0; tick = 1'b0;
        d = dout;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        read_reg(a, 1'b0, d);
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] seq_exp [5];
        seq_exp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; tick = 1'b0; cs = 1'b0; we = 1'b0; addr = 4'h0; di = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_dout",  {8'h00, dout}, 16'h0000);
        check("rst_irq_n", {15'h0000, irq_n}, 16'h0001);
        read_check("rst_ta_lo", REG_TA_LO, 8'h00);
        read_check("rst_cra",   REG_CRA,   8'h00);
        read_check("rst_icr",   REG_ICR,   8'h00);

        // Continuous mode, latch 3: counter reads 3,2,1,0,3
        write_reg(REG_TA_LO, 8'h03, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        read_check("ta_load", REG_TA_LO, 8'h03);
        write_reg(REG_CRA, 8'h01, 1'b0);
        cs = 1'b1; we = 1'b0; addr = REG_TA_LO; tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("ta_seq%0d", i), {8'h00, dout}, {8'h00, seq_exp[i]});
        end
        cs = 1'b0; tick = 1'b0;
        read_check("cont_icr1", REG_ICR, 8'h01);
        read_check("cont_icr2", REG_ICR, 8'h00);

        // One-shot with interrupt enabled
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_ICR, 8'h81, 1'b0);
        write_reg(REG_TA_LO, 8'h03, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        write_reg(REG_CRA, 8'h09, 1'b0);
        tick = 1'b1;
        repeat (4) @(negedge clk);
        check("os_irq_pre", {15'h0000, irq_n}, 16'h0001);
        @(negedge clk);
        check("os_irq_low", {15'h0000, irq_n}, 16'h0000);
        repeat (3) @(negedge clk);
        tick = 1'b0;
        read_check("os_cra",   REG_CRA,   8'h08);
        read_check("os_ta_lo", REG_TA_LO, 8'h03);
        read_check("os_icr1",  REG_ICR,   8'h81);
        read_check("os_icr2",  REG_ICR,   8'h00);
        check("os_irq_rel", {15'h0000, irq_n}, 16'h0001);

        // Cascade: TB counts TA underflows
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_ICR, 8'h01, 1'b0);
        write_reg(REG_TA_LO, 8'h01, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        write_reg(REG_TB_LO, 8'h02, 1'b0);
        write_reg(REG_TB_HI, 8'h00, 1'b0);
        write_reg(REG_CRB, 8'h41, 1'b0);
        write_reg(REG_CRA, 8'h01, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        repeat (5) @(negedge clk);
        tick = 1'b0;
        read_check("casc_tb5",  REG_TB_LO, 8'h00);
        read_check("casc_icr5", REG_ICR,   8'h01);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        read_check("casc_icr6", REG_ICR,   8'h03);
        read_check("casc_tb6",  REG_TB_LO, 8'h02);

        // Underflow in the same cycle as an ICR read
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_CRB, 8'h00, 1'b0);
        write_reg(REG_TA_LO, 8'h00, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        write_reg(REG_CRA, 8'h01, 1'b0);
        read_reg(REG_ICR, 1'b1, d);
        check("race_old", {8'h00, d}, 16'h0000);
        read_check("race_kept", REG_ICR, 8'h01);

        // High-byte write while running, then force load while ticking
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_TA_LO, 8'h05, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        write_reg(REG_CRA, 8'h01, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        write_reg(REG_TA_HI, 8'h01, 1'b0);
        read_check("run_hi_lo", REG_TA_LO, 8'h03);
        read_check("run_hi_hi", REG_TA_HI, 8'h00);
        write_reg(REG_CRA, 8'h11, 1'b1);
        read_check("fl_lo",  REG_TA_LO, 8'h05);
        read_check("fl_hi",  REG_TA_HI, 8'h01);
        read_check("fl_cra", REG_CRA,   8'h01);

        // Reset while counting
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_ICR, 8'h81, 1'b0);
        write_reg(REG_TA_LO, 8'h02, 1'b0);
        write_reg(REG_TA_HI, 8'h00, 1'b0);
        write_reg(REG_CRA, 8'h01, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        check("mr_dout",  {8'h00, dout}, 16'h0000);
        check("mr_irq_n", {15'h0000, irq_n}, 16'h0001);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        read_check("mr_ta_lo", REG_TA_LO, 8'h00);
        read_check("mr_ta_hi", REG_TA_HI, 8'h00);
        read_check("mr_tb_lo", REG_TB_LO, 8'h00);
        read_check("mr_cra",   REG_CRA,   8'h00);
        read_check("mr_crb",   REG_CRB,   8'h00);
        read_check("mr_icr",   REG_ICR,   8'h00);
        check("mr_irq_post", {15'h0000, irq_n}, 16'h0001);
        write_reg(REG_CRA, 8'h10, 1'b0);
        read_check("mr_latch", REG_TA_LO, 8'hFF);

        // Control-register bit masks, unmapped indices, dout hold
        write_reg(REG_CRA, 8'hFF, 1'b0);
        read_check("cra_bits", REG_CRA, 8'h29);
        write_reg(REG_CRA, 8'h00, 1'b0);
        write_reg(REG_CRB, 8'hFF, 1'b0);
        read_check("crb_bits", REG_CRB, 8'h69);
        write_reg(REG_CRB, 8'h00, 1'b0);
        read_check("crb_clr", REG_CRB, 8'h00);
        read_check("cra_clr", REG_CRA, 8'h00);
        write_reg(4'h0, 8'h5A, 1'b0);
        check("dout_hold", {8'h00, dout}, 16'h0000);
        read_check("unmapped0", 4'h0, 8'h00);
        read_check("unmapped3", 4'h3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
